// File: rtl/wb_writer.sv
// Writeback queue: buffers {rd, data} results and drains one per unheld cycle to the register file.
// Optional macro WB_WRITER_FORWARD_EN enables youngest-match forwarding lookups on rs1/rs2.
module wb_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(DATA_WIDTH)-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          hold,
  output logic                          reg_write,
  output logic [$clog2(DATA_WIDTH)-1:0] rd,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic [$clog2(DATA_WIDTH)-1:0] rs1,
  input  logic [$clog2(DATA_WIDTH)-1:0] rs2,
  output logic                          fwd1_hit,
  output logic                          fwd2_hit,
  output logic [DATA_WIDTH-1:0]         fwd1_data,
  output logic [DATA_WIDTH-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int RW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [RW-1:0]         mem_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  accept, push, pop;

  assign in_ready = (count_q < FULL);
  assign accept   = in_valid && in_ready;
  // x0 results complete the handshake but are never stored
  assign push     = accept && (in_rd != '0);
  assign pop      = reg_write;

  assign reg_write = (count_q != '0) && !hold;
  assign rd        = (count_q != '0) ? mem_rd_q[rd_ptr_q]   : '0;
  assign rd_data   = (count_q != '0) ? mem_data_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= in_rd;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef WB_WRITER_FORWARD_EN
  // Scan oldest to youngest so the last match seen is the youngest pending value
  always_comb begin
    logic [PW-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (rs1 != '0 && mem_rd_q[idx] == rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data_q[idx];
        end
        if (rs2 != '0 && mem_rd_q[idx] == rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data_q[idx];
        end
      end
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: single write, x0 drop, full-under-hold, push/pop overlap,
// forwarding (expectations follow WB_WRITER_FORWARD_EN) and reset mid-drain.
module tb_wb_writer;

  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, hold, reg_write;
  logic [4:0]    in_rd, rd, rs1, rs2;
  logic [DW-1:0] in_data, rd_data, fwd1_data, fwd2_data;
  logic          fwd1_hit, fwd2_hit;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

`ifdef WB_WRITER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  wb_writer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .hold(hold), .reg_write(reg_write),
    .rd(rd), .rd_data(rd_data), .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; inputs are driven at +1, checks at +2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [DW-1:0] d);
    in_valid = v;
    in_rd    = r;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; rs1 = '0; rs2 = '0;
    drive(1'b0, 5'd0, '0);
    #2;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd", rd, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fwd1_hit", fwd1_hit, 0);
    chk("rst_fwd2_data", fwd2_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single write
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, '0);
    #1;
    chk("single_reg_write", reg_write, 1);
    chk("single_rd", rd, 5);
    chk("single_rd_data", rd_data, 32'hDEADBEEF);
    chk("single_count", count, 1);
    tick(); #1;
    chk("single_count_after", count, 0);
    chk("single_reg_write_after", reg_write, 0);

    // x0 drop
    drive(1'b1, 5'd0, 32'h12345678);
    #1;
    chk("x0_in_ready", in_ready, 1);
    tick();
    drive(1'b0, 5'd0, '0);
    #1;
    chk("x0_count", count, 0);
    chk("x0_reg_write", reg_write, 0);
    tick(); #1;
    chk("x0_reg_write_late", reg_write, 0);

    // fill under hold
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    drive(1'b1, 5'd9, 32'h999);
    #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_reg_write", reg_write, 0);
    chk("full_rd_head", rd, 1);
    chk("full_rd_data_head", rd_data, 32'h101);
    tick();
    drive(1'b0, 5'd0, '0);
    #1;
    chk("full_no_accept", count, 4);
    chk("full_rd_stable", rd, 1);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_reg_write", reg_write, 1);
      chk("drain_rd", rd, 5'(i));
      chk("drain_rd_data", rd_data, 32'h100 + 32'(i));
      tick();
    end
    #1;
    chk("drain_empty", count, 0);
    chk("drain_reg_write_off", reg_write, 0);

    // simultaneous push and pop
    drive(1'b1, 5'd10, 32'hAAAA0001);
    tick();
    drive(1'b1, 5'd11, 32'hBBBB0002);
    #1;
    chk("pp_rd_first", rd, 10);
    tick();
    drive(1'b0, 5'd0, '0);
    #1;
    chk("pp_count", count, 1);
    chk("pp_rd_second", rd, 11);
    chk("pp_rd_data_second", rd_data, 32'hBBBB0002);
    tick(); #1;
    chk("pp_empty", count, 0);

    // forwarding
    hold = 1'b1;
    drive(1'b1, 5'd7, 32'h1); tick();
    drive(1'b1, 5'd7, 32'h2); tick();
    drive(1'b0, 5'd0, '0);
    rs1 = 5'd7; rs2 = 5'd0;
    #1;
    chk("fwd1_hit", fwd1_hit, FWD ? 1 : 0);
    chk("fwd1_data_youngest", fwd1_data, FWD ? 32'h2 : 32'h0);
    chk("fwd2_hit_x0", fwd2_hit, 0);
    chk("fwd2_data_x0", fwd2_data, 0);
    rs2 = 5'd3;
    #1;
    chk("fwd2_hit_miss", fwd2_hit, 0);
    rs1 = '0; rs2 = '0;
    hold = 1'b0;
    #1;
    chk("fwd_drain1_data", rd_data, 32'h1);
    tick(); #1;
    chk("fwd_drain2_rd", rd, 7);
    chk("fwd_drain2_data", rd_data, 32'h2);
    tick(); #1;
    chk("fwd_empty", count, 0);

    // reset mid-drain
    hold = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h200 + 32'(i));
      tick();
    end
    drive(1'b0, 5'd0, '0);
    hold = 1'b0;
    #1;
    chk("mid_count", count, 3);
    chk("mid_reg_write", reg_write, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    drive(1'b1, 5'd6, 32'h666);
    tick(); #1;
    chk("mid_rst_inflight_dropped", count, 0);
    chk("mid_rst_no_write", reg_write, 0);
    drive(1'b0, 5'd0, '0);
    rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_reg_write", reg_write, 0);
    tick(); #1;
    chk("post_rst_reg_write_late", reg_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer offers a writeback result.
REQ-006 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-007 SHALL have port in_rd  input  $clog2(DATA_WIDTH)  destination register index.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  result value.
REQ-009 SHALL have port hold  input  1  pause draining toward the register file.
REQ-010 SHALL have port reg_write  output  1  register-file write enable.
REQ-011 SHALL have port rd  output  $clog2(DATA_WIDTH)  register-file write address.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  register-file write data.
REQ-013 SHALL have ports rs1, rs2  input  $clog2(DATA_WIDTH) each  forwarding lookup indices.
REQ-014 SHALL have ports fwd1_hit, fwd2_hit  output  1 each  pending value exists for rs1/rs2.
REQ-015 SHALL have ports fwd1_data, fwd2_data  output  DATA_WIDTH each  pending value for rs1/rs2.
REQ-016 SHALL have port count  output  $clog2(DATA_WIDTH)+1... no: $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL implement a FIFO of DEPTH entries {rd, data} with wrapping read/write pointers.
REQ-018 SHALL accept an entry on a rising edge where in_valid && in_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH); no pass-through when full, even if a pop occurs that cycle.
REQ-020 SHALL discard accepted entries with in_rd == 0 (handshake completes, nothing stored, count unchanged).
REQ-021 SHALL drive reg_write = (count != 0) && !hold; rd/rd_data = head entry, zero when empty.
REQ-022 SHALL pop the head on every rising edge where reg_write is 1; the register file commits on that same edge.
REQ-023 SHALL give latency: entry accepted at edge N into an empty queue -> reg_write high during cycle N..N+1, committed at edge N+1.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-025 SHALL drain entries in acceptance order, one per unheld cycle; same-index entries are all written in order.
REQ-026 SHALL, while hold is 1, keep rd/rd_data stable at head and keep accepting until full.

Reset
REQ-027 SHALL, when rst_n is low, asynchronously clear pointers and count; queued entries are lost.
REQ-028 SHALL hold outputs during reset at: reg_write 0, rd 0, rd_data 0, count 0, in_ready 1, fwd hits 0, fwd data 0.
REQ-029 SHALL discard, on reset asserted mid-operation, any in-flight handshake; no register-file write occurs while rst_n is low.

Configuration
REQ-030 SHALL, with macro WB_WRITER_FORWARD_EN defined, drive fwdN_hit = 1 when any queued entry matches rsN (rsN != 0), and fwdN_data = data of the youngest match; combinational.
REQ-031 SHALL, without WB_WRITER_FORWARD_EN, tie fwd1_hit, fwd2_hit, fwd1_data, fwd2_data to 0 with no lookup logic; ports remain present.

Verification
REQ-032 SHALL cover single write: push (rd=5, 0xDEADBEEF) into empty queue -> next cycle reg_write=1, rd=5, rd_data=0xDEADBEEF; count returns to 0 after one edge.
REQ-033 SHALL cover x0 drop: push (rd=0, 0x12345678) -> in_ready stays 1, count stays 0, reg_write never asserts.
REQ-034 SHALL cover full under hold: hold=1, push 4 entries (rd=1..4) -> count=4, in_ready=0; release hold -> writes rd=1,2,3,4 on 4 consecutive edges.
REQ-035 SHALL cover forwarding with macro: queue (rd=7, 0x1), (rd=7, 0x2), hold=1, rs1=7, rs2=0 -> fwd1_hit=1, fwd1_data=0x2, fwd2_hit=0.
REQ-036 SHALL cover reset mid-drain: 3 entries queued, rst_n low between edges -> reg_write=0 and count=0 immediately, no further writes after release.
